// File: rtl/serial_result_writer_if.sv
// Bundles the start/config, core-handshake and output-RAM write signals of serial_result_writer.
// The master modport is the environment side; the slave modport is the writer itself.
interface serial_result_writer_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start_i;
    logic [7:0]        feat_base_i;
    logic [ADDR_W-1:0] out_base_i;
    logic              core_done_i;
    logic [7:0]        core_data_i;
    logic              core_clr_o;
    logic              core_en_o;
    logic [7:0]        core_feat_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    modport master (
        output start_i, feat_base_i, out_base_i, core_done_i, core_data_i,
        input  core_clr_o, core_en_o, core_feat_o, wr_en_o, wr_addr_o, wr_data_o,
        input  busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, feat_base_i, out_base_i, core_done_i, core_data_i,
        output core_clr_o, core_en_o, core_feat_o, wr_en_o, wr_addr_o, wr_data_o,
        output busy_o, done_o, err_o
    );
endinterface

// File: rtl/serial_result_writer.sv
// Sequences the serial MAC core over NUM_OUT output positions: clear, launch at a strided
// feature address, wait for done, then write the (optionally ReLU'd) result to the output RAM.
module serial_result_writer #(
    parameter int unsigned NUM_OUT     = 4,
    parameter int unsigned FEAT_STRIDE = 1,
    parameter int unsigned ADDR_W      = 6,
    parameter bit          RELU_EN     = 1'b1,
    parameter int unsigned TIMEOUT     = 255
) (
    input logic                   clk,
    input logic                   rst,
    serial_result_writer_if.slave bus
);
    localparam int unsigned       IDX_W    = 8;
    localparam int unsigned       TMR_W    = 8;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OUT - 1);
    localparam logic [TMR_W-1:0]  TMR_MAX  = TMR_W'(TIMEOUT);
    localparam logic [7:0]        STRIDE   = 8'(FEAT_STRIDE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [TMR_W-1:0]  timer;
    logic [7:0]        feat_addr;
    logic [ADDR_W-1:0] out_addr;
    logic              accept;

    assign accept          = (state == S_IDLE) && bus.start_i;
    assign bus.core_feat_o = feat_addr;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; core_done_i only matters in WAIT so a stale flag in LAUNCH is ignored
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start_i) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (bus.core_done_i) begin
                    state_nxt = S_WRITE;
                end else if (timer == TMR_MAX) begin
                    state_nxt = S_ERR;
                end
            end
            S_WRITE:  state_nxt = (idx == LAST_IDX) ? S_DONE : S_CLEAR;
            S_DONE:   state_nxt = S_IDLE;
            S_ERR:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Position index, running feature/output addresses and WAIT timer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            timer     <= '0;
            feat_addr <= '0;
            out_addr  <= '0;
        end else begin
            if (accept) begin
                idx       <= '0;
                feat_addr <= bus.feat_base_i;
                out_addr  <= bus.out_base_i;
            end else if (state == S_WRITE) begin
                idx      <= idx + IDX_W'(1);
                out_addr <= out_addr + ADDR_W'(1);
                if (state_nxt == S_CLEAR) begin
                    feat_addr <= feat_addr + STRIDE;
                end
            end
            timer <= (state == S_WAIT) ? timer + TMR_W'(1) : '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.core_clr_o <= 1'b0;
            bus.core_en_o  <= 1'b0;
            bus.wr_en_o    <= 1'b0;
            bus.wr_addr_o  <= '0;
            bus.wr_data_o  <= '0;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
            bus.err_o      <= 1'b0;
        end else begin
            bus.core_clr_o <= (state_nxt == S_CLEAR);
            bus.core_en_o  <= (state_nxt == S_LAUNCH) || (state_nxt == S_WAIT);
            bus.wr_en_o    <= (state_nxt == S_WRITE);
            bus.wr_addr_o  <= (state_nxt == S_WRITE) ? out_addr : '0;
            // WRITE is only entered from WAIT on core_done_i, so this captures the core result
            if (state_nxt == S_WRITE) begin
                bus.wr_data_o <= (RELU_EN && bus.core_data_i[7]) ? 8'h00 : bus.core_data_i;
            end else begin
                bus.wr_data_o <= 8'h00;
            end
            bus.busy_o     <= (state_nxt != S_IDLE);
            bus.done_o     <= (state_nxt == S_DONE);
            if (state_nxt == S_ERR) begin
                bus.err_o <= 1'b1;
            end else if (accept) begin
                bus.err_o <= 1'b0;
            end
        end
    end
endmodule
